rbm_bernoulli_sampler: RTL

RBM_BERNOULLI_SAMPLER -- requirements
Module: rbm_bernoulli_sampler

---
 rtl/rbm_pkg.sv | 21 ++
 rtl/rbm_bernoulli_sampler_if.sv | 38 +++
 rtl/rbm_lfsr.sv | 40 ++++
 rtl/rbm_bernoulli_sampler.sv | 97 +++++++++
 4 files changed

// File: rtl/rbm_pkg.sv
// rbm_pkg: constants shared by the RBM hidden-unit sampler and the
// sigmoid_lut consumers.
//   PROB_W    - probability width, Q0.16
//   LFSR_W    - random-source width
//   LFSR_MASK - Galois mask for x^32+x^22+x^2+x+1
//   LFSR_SEED - default (nonzero) LFSR seed
//   ONES_W    - width of the optional per-frame ones counter
package rbm_pkg;
    localparam int unsigned PROB_W    = 16;
    localparam int unsigned LFSR_W    = 32;
    localparam int unsigned ONES_W    = 16;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;

    typedef logic [ONES_W-1:0] ones_t;

    // Saturating increment of the ones counter.
    function automatic ones_t ones_inc(input ones_t v);
        return (v == '1) ? v : ones_t'(v + 1'b1);
    endfunction
endpackage

// File: rtl/rbm_bernoulli_sampler_if.sv
// rbm_bernoulli_sampler_if: probability-in / sample-out streaming bundle.
//   s_valid/s_ready/s_prob/s_last : upstream probability beat
//   m_valid/m_ready/m_bit/m_prob/m_last : downstream sampled beat
//   m_ones : per-frame count of ones (only with RBM_SAMPLER_STATS_EN)
// Modport slave is the sampler's view; master is the surrounding
// environment (drives upstream beats, consumes samples).
interface rbm_bernoulli_sampler_if #(
    parameter int unsigned PROB_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [PROB_W-1:0] s_prob;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic              m_bit;
    logic [PROB_W-1:0] m_prob;
    logic              m_last;
`ifdef RBM_SAMPLER_STATS_EN
    logic [15:0]       m_ones;
`endif

    modport slave (
        input  s_valid, s_prob, s_last, m_ready,
        output s_ready, m_valid, m_bit, m_prob, m_last
`ifdef RBM_SAMPLER_STATS_EN
        , output m_ones
`endif
    );

    modport master (
        output s_valid, s_prob, s_last, m_ready,
        input  s_ready, m_valid, m_bit, m_prob, m_last
`ifdef RBM_SAMPLER_STATS_EN
        , input m_ones
`endif
    );
endinterface

// File: rtl/rbm_lfsr.sv
// rbm_lfsr: right-shifting Galois LFSR random source.
//   clk, rst : clock, synchronous active-high reset (state <- SEED)
//   i_en     : advance one step
//   i_load   : load i_seed (wins over i_en); zero seed maps to SEED
//   i_seed   : seed value
//   o_state  : current LFSR state
module rbm_lfsr
    import rbm_pkg::*;
#(
    parameter int unsigned     W    = LFSR_W,
    parameter logic [W-1:0]    MASK = LFSR_MASK[W-1:0],
    parameter logic [W-1:0]    SEED = LFSR_SEED[W-1:0]
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_seed,
    output logic [W-1:0] o_state
);
    logic [W-1:0] r_state;
    logic [W-1:0] w_next;

    always_comb begin
        w_next = {1'b0, r_state[W-1:1]} ^ (r_state[0] ? MASK : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_load) begin
            // An all-zero state would lock up, so fall back to SEED.
            r_state <= (i_seed == '0) ? SEED : i_seed;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;
endmodule

// File: rtl/rbm_bernoulli_sampler.sv
// rbm_bernoulli_sampler: draws h ~ Bernoulli(p) for each hidden-unit
// probability beat, with one registered output stage (1-cycle latency,
// full throughput).
//   clk, rst  : clock, synchronous active-high reset
//   seed_load : load seed into the LFSR on the next edge
//   seed      : LFSR seed (zero selects SEED)
//   bus       : slave side of rbm_bernoulli_sampler_if
// Optional feature: define RBM_SAMPLER_STATS_EN to add bus.m_ones, the
// saturating count of ones in the current frame including this beat.
module rbm_bernoulli_sampler
    import rbm_pkg::*;
#(
    parameter int unsigned       PROB_W = rbm_pkg::PROB_W,
    parameter int unsigned       LFSR_W = rbm_pkg::LFSR_W,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_SEED[LFSR_W-1:0]
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_load,
    input  logic [LFSR_W-1:0]     seed,
    rbm_bernoulli_sampler_if.slave bus
);
    logic [LFSR_W-1:0] w_lfsr;
    logic [PROB_W-1:0] w_r;
    logic              w_s_ready;
    logic              w_accept;
    logic              w_bit;
    logic              w_unused_lfsr_hi;

    logic              r_m_valid;
    logic              r_m_bit;
    logic [PROB_W-1:0] r_m_prob;
    logic              r_m_last;

    assign w_s_ready        = !r_m_valid || bus.m_ready;
    assign w_accept         = bus.s_valid && w_s_ready;
    assign w_r              = w_lfsr[PROB_W-1:0];
    assign w_unused_lfsr_hi = ^w_lfsr[LFSR_W-1:PROB_W];
    assign w_bit            = (w_r < bus.s_prob);

    // The beat accepted alongside a seed load samples the pre-load state
    // because the LFSR output is registered.
    rbm_lfsr #(
        .W    (LFSR_W),
        .MASK (LFSR_MASK[LFSR_W-1:0]),
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_accept),
        .i_load  (seed_load),
        .i_seed  (seed),
        .o_state (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_bit   <= 1'b0;
            r_m_prob  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_bit   <= w_bit;
            r_m_prob  <= bus.s_prob;
            r_m_last  <= bus.s_last;
        end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

`ifdef RBM_SAMPLER_STATS_EN
    ones_t r_m_ones;
    ones_t w_ones_base;

    // The next accept can only happen once the held beat has transferred,
    // so "clear after the m_last beat transfers" reduces to restarting the
    // count when the previously captured beat closed a frame.
    assign w_ones_base = r_m_last ? '0 : r_m_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_ones <= '0;
        end else if (w_accept) begin
            r_m_ones <= w_bit ? ones_inc(w_ones_base) : w_ones_base;
        end
    end

    assign bus.m_ones = r_m_ones;
`endif

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_bit   = r_m_bit;
    assign bus.m_prob  = r_m_prob;
    assign bus.m_last  = r_m_last;
endmodule
